// File: rtl/mux_scan_nx1.sv
// Registered N:1 word multiplexer with manual select and an optional round-robin scanner.
// Optional feature macro: MUX_SCAN_EN (scan state, cur_ch/dwell_cnt counters and wrap pulse).
//
// state     | meaning
// ST_IDLE   | disabled: outp/out_ch hold, flags low, scan counters cleared
// ST_MANUAL | outp follows inp[sel]; err flags sel >= CHANNELS
// ST_SCAN   | outp follows inp[cur_ch]; each channel held for DWELL cycles
module mux_scan_nx1 #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DWELL    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] inp,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  input  logic                      en,
  output logic [WIDTH-1:0]          outp,
  output logic [SEL_W-1:0]          out_ch,
  output logic                      out_vld,
  output logic                      wrap,
  output logic                      err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_outp;
  logic [SEL_W-1:0] r_out_ch;
  logic             r_out_vld;
  logic             r_err;

  logic [WIDTH-1:0] w_outp_nxt;
  logic [SEL_W-1:0] w_out_ch_nxt;
  logic             w_out_vld_nxt;
  logic             w_err_nxt;

  logic [SEL_W-1:0] w_mux_sel;
  logic [WIDTH-1:0] w_mux_word;
  logic             w_sel_bad;

`ifdef MUX_SCAN_EN
  localparam int DW_W = $clog2(DWELL) + 1;
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] LAST_CH    = SEL_W'(CHANNELS - 1);

  logic [SEL_W-1:0] r_cur_ch;
  logic [DW_W-1:0]  r_dwell_cnt;
  logic             r_wrap;
  logic [SEL_W-1:0] w_cur_ch_nxt;
  logic [DW_W-1:0]  w_dwell_cnt_nxt;
  logic             w_wrap_nxt;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = mode & (DWELL > 0);
`endif

  assign w_sel_bad = (int'(sel) >= CHANNELS);

  // Counters are zero on every entry to ST_SCAN because every other state clears them.
`ifdef MUX_SCAN_EN
  assign w_mux_sel = (w_state_nxt == ST_SCAN) ? r_cur_ch : sel;
`else
  assign w_mux_sel = sel;
`endif

  // Loop compare keeps an out-of-range select from indexing past the packed input.
  always_comb begin
    w_mux_word = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (int'(w_mux_sel) == k) begin
        w_mux_word = inp[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    w_state_nxt     = ST_IDLE;
    w_outp_nxt      = r_outp;
    w_out_ch_nxt    = r_out_ch;
    w_out_vld_nxt   = 1'b0;
    w_err_nxt       = 1'b0;
`ifdef MUX_SCAN_EN
    w_cur_ch_nxt    = '0;
    w_dwell_cnt_nxt = '0;
    w_wrap_nxt      = 1'b0;
`endif

    if (en) begin
`ifdef MUX_SCAN_EN
      w_state_nxt = mode ? ST_SCAN : ST_MANUAL;
`else
      w_state_nxt = ST_MANUAL;
`endif
    end

    case (w_state_nxt)
      ST_MANUAL: begin
        w_out_ch_nxt = sel;
        if (w_sel_bad) begin
          w_outp_nxt = '0;
          w_err_nxt  = 1'b1;
        end else begin
          w_outp_nxt    = w_mux_word;
          w_out_vld_nxt = 1'b1;
        end
      end
`ifdef MUX_SCAN_EN
      ST_SCAN: begin
        w_outp_nxt    = w_mux_word;
        w_out_ch_nxt  = r_cur_ch;
        w_out_vld_nxt = 1'b1;
        if (r_dwell_cnt == DWELL_LAST) begin
          w_dwell_cnt_nxt = '0;
          w_cur_ch_nxt    = (r_cur_ch == LAST_CH) ? '0 : r_cur_ch + SEL_W'(1);
          w_wrap_nxt      = (r_cur_ch == LAST_CH);
        end else begin
          w_dwell_cnt_nxt = r_dwell_cnt + DW_W'(1);
          w_cur_ch_nxt    = r_cur_ch;
        end
      end
`endif
      default: begin
        w_outp_nxt   = r_outp;
        w_out_ch_nxt = r_out_ch;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_outp      <= '0;
      r_out_ch    <= '0;
      r_out_vld   <= 1'b0;
      r_err       <= 1'b0;
`ifdef MUX_SCAN_EN
      r_cur_ch    <= '0;
      r_dwell_cnt <= '0;
      r_wrap      <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_outp      <= w_outp_nxt;
      r_out_ch    <= w_out_ch_nxt;
      r_out_vld   <= w_out_vld_nxt;
      r_err       <= w_err_nxt;
`ifdef MUX_SCAN_EN
      r_cur_ch    <= w_cur_ch_nxt;
      r_dwell_cnt <= w_dwell_cnt_nxt;
      r_wrap      <= w_wrap_nxt;
`endif
    end
  end

  assign outp    = r_outp;
  assign out_ch  = r_out_ch;
  assign out_vld = r_out_vld;
  assign err     = r_err;
`ifdef MUX_SCAN_EN
  assign wrap    = r_wrap;
`else
  assign wrap    = 1'b0;
`endif

endmodule

// File: tb/tb_mux_scan_nx1.sv
// Directed bench for mux_scan_nx1: a 4-channel/DWELL=2 instance and a 3-channel/DWELL=1 instance.
// Scan sequences are checked only when MUX_SCAN_EN is defined; otherwise mode=1 must act as manual.
module tb_mux_scan_nx1;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        mode;
  logic [1:0]  sel;
  logic [31:0] inp4;
  logic [23:0] inp3;

  logic [7:0] o4_outp;
  logic [1:0] o4_ch;
  logic       o4_vld, o4_wrap, o4_err;
  logic [7:0] o3_outp;
  logic [1:0] o3_ch;
  logic       o3_vld, o3_wrap, o3_err;

  assign inp3 = inp4[23:0];

  always #5 clk = ~clk;

  mux_scan_nx1 #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .DWELL(2)) dut4 (
    .clk(clk), .rst(rst), .inp(inp4), .sel(sel), .mode(mode), .en(en),
    .outp(o4_outp), .out_ch(o4_ch), .out_vld(o4_vld), .wrap(o4_wrap), .err(o4_err)
  );

  mux_scan_nx1 #(.WIDTH(8), .CHANNELS(3), .SEL_W(2), .DWELL(1)) dut3 (
    .clk(clk), .rst(rst), .inp(inp3), .sel(sel), .mode(mode), .en(en),
    .outp(o3_outp), .out_ch(o3_ch), .out_vld(o3_vld), .wrap(o3_wrap), .err(o3_err)
  );

  int n_vec  = 0;
  int n_miss = 0;

  localparam logic [31:0] D0 = 32'h44332211;

  typedef struct {
    logic        r, e, m;
    logic [1:0]  s;
    logic [31:0] d;
    logic [12:0] x4, x3;
  } vec_t;

  vec_t tbl[14];

  function automatic logic [12:0] pk(logic [7:0] o, logic [1:0] c, logic v, logic w, logic er);
    return {o, c, v, w, er};
  endfunction

  // word presented by channel c of D0 (0x11, 0x22, 0x33, 0x44)
  function automatic logic [7:0] wd(int c);
    return 8'(17 * (c + 1));
  endfunction

  task automatic chk(input string nm, input logic [12:0] act, input logic [12:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got outp=%h ch=%0d vld=%b wrap=%b err=%b, want outp=%h ch=%0d vld=%b wrap=%b err=%b",
               nm, act[12:5], act[4:3], act[2], act[1], act[0],
               exp[12:5], exp[4:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic step(input string nm, input logic r, input logic e, input logic m,
                      input logic [1:0] s, input logic [31:0] d,
                      input logic [12:0] x4, input logic [12:0] x3);
    rst = r; en = e; mode = m; sel = s; inp4 = d;
    @(posedge clk);
    #1;
    chk({nm, "/c4"}, {o4_outp, o4_ch, o4_vld, o4_wrap, o4_err}, x4);
    chk({nm, "/c3"}, {o3_outp, o3_ch, o3_vld, o3_wrap, o3_err}, x3);
  endtask

`ifdef MUX_SCAN_EN
  // n4: DWELL=2 over 4 channels; n3: DWELL=1 over 3 channels
  task automatic scan_run(input string nm, input int n);
    for (int i = 0; i < n; i++) begin
      int c4, c3;
      c4 = (i / 2) % 4;
      c3 = i % 3;
      step(nm, 1'b0, 1'b1, 1'b1, 2'd3, D0,
           pk(wd(c4), 2'(c4), 1'b1, (i % 8) == 7, 1'b0),
           pk(wd(c3), 2'(c3), 1'b1, (i % 3) == 2, 1'b0));
    end
  endtask
`endif

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 2'd2, D0,           pk(8'h00, 2'd0, 1'b0, 1'b0, 1'b0), pk(8'h00, 2'd0, 1'b0, 1'b0, 1'b0)};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 2'd2, D0,           pk(8'h00, 2'd0, 1'b0, 1'b0, 1'b0), pk(8'h00, 2'd0, 1'b0, 1'b0, 1'b0)};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 2'd2, D0,           pk(8'h33, 2'd2, 1'b1, 1'b0, 1'b0), pk(8'h33, 2'd2, 1'b1, 1'b0, 1'b0)};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 2'd3, D0,           pk(8'h44, 2'd3, 1'b1, 1'b0, 1'b0), pk(8'h00, 2'd3, 1'b0, 1'b0, 1'b1)};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 2'd1, D0,           pk(8'h22, 2'd1, 1'b1, 1'b0, 1'b0), pk(8'h22, 2'd1, 1'b1, 1'b0, 1'b0)};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 2'd1, 32'hA5B6C7D8, pk(8'hC7, 2'd1, 1'b1, 1'b0, 1'b0), pk(8'hC7, 2'd1, 1'b1, 1'b0, 1'b0)};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 2'd0, 32'hA5B6C7D8, pk(8'hC7, 2'd1, 1'b0, 1'b0, 1'b0), pk(8'hC7, 2'd1, 1'b0, 1'b0, 1'b0)};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 2'd3, 32'h01020304, pk(8'hC7, 2'd1, 1'b0, 1'b0, 1'b0), pk(8'hC7, 2'd1, 1'b0, 1'b0, 1'b0)};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 2'd3, 32'h01020304, pk(8'h01, 2'd3, 1'b1, 1'b0, 1'b0), pk(8'h00, 2'd3, 1'b0, 1'b0, 1'b1)};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 2'd3, 32'h01020304, pk(8'h01, 2'd3, 1'b0, 1'b0, 1'b0), pk(8'h00, 2'd3, 1'b0, 1'b0, 1'b0)};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 2'd0, D0,           pk(8'h11, 2'd0, 1'b1, 1'b0, 1'b0), pk(8'h11, 2'd0, 1'b1, 1'b0, 1'b0)};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 2'd2, D0,           pk(8'h00, 2'd0, 1'b0, 1'b0, 1'b0), pk(8'h00, 2'd0, 1'b0, 1'b0, 1'b0)};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 2'd2, D0,           pk(8'h00, 2'd0, 1'b0, 1'b0, 1'b0), pk(8'h00, 2'd0, 1'b0, 1'b0, 1'b0)};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 2'd0, D0,           pk(8'h11, 2'd0, 1'b1, 1'b0, 1'b0), pk(8'h11, 2'd0, 1'b1, 1'b0, 1'b0)};

    for (int i = 0; i < 14; i++) begin
      step($sformatf("tbl%0d", i), tbl[i].r, tbl[i].e, tbl[i].m, tbl[i].s, tbl[i].d, tbl[i].x4, tbl[i].x3);
    end

`ifdef MUX_SCAN_EN
    // full scan from IDLE, sel ignored
    step("idleA", 1'b0, 1'b0, 1'b0, 2'd0, D0, pk(8'h11, 2'd0, 1'b0, 1'b0, 1'b0), pk(8'h11, 2'd0, 1'b0, 1'b0, 1'b0));
    scan_run("scanA", 10);

    // manual interruption during channel 1, then restart from channel 0 with a live data change
    step("idleB", 1'b0, 1'b0, 1'b1, 2'd3, D0, pk(8'h11, 2'd0, 1'b0, 1'b0, 1'b0), pk(8'h11, 2'd0, 1'b0, 1'b0, 1'b0));
    scan_run("scanB", 3);
    step("manB", 1'b0, 1'b1, 1'b0, 2'd3, D0, pk(8'h44, 2'd3, 1'b1, 1'b0, 1'b0), pk(8'h00, 2'd3, 1'b0, 1'b0, 1'b1));
    step("rescanB0", 1'b0, 1'b1, 1'b1, 2'd3, D0, pk(8'h11, 2'd0, 1'b1, 1'b0, 1'b0), pk(8'h11, 2'd0, 1'b1, 1'b0, 1'b0));
    step("rescanB1", 1'b0, 1'b1, 1'b1, 2'd3, 32'h443322EE, pk(8'hEE, 2'd0, 1'b1, 1'b0, 1'b0), pk(8'h22, 2'd1, 1'b1, 1'b0, 1'b0));
    step("rescanB2", 1'b0, 1'b1, 1'b1, 2'd3, D0, pk(8'h22, 2'd1, 1'b1, 1'b0, 1'b0), pk(8'h33, 2'd2, 1'b1, 1'b1, 1'b0));

    // reset on the second cycle of channel 2, then a full clean period
    step("idleC", 1'b0, 1'b0, 1'b0, 2'd0, D0, pk(8'h22, 2'd1, 1'b0, 1'b0, 1'b0), pk(8'h33, 2'd2, 1'b0, 1'b0, 1'b0));
    scan_run("scanC", 5);
    step("rstC", 1'b1, 1'b1, 1'b1, 2'd3, D0, pk(8'h00, 2'd0, 1'b0, 1'b0, 1'b0), pk(8'h00, 2'd0, 1'b0, 1'b0, 1'b0));
    scan_run("postC", 8);
`else
    for (int i = 0; i < 4; i++) begin
      step("nomacro", 1'b0, 1'b1, 1'b1, 2'd1, D0, pk(8'h22, 2'd1, 1'b1, 1'b0, 1'b0), pk(8'h22, 2'd1, 1'b1, 1'b0, 1'b0));
    end
    step("nomacro_oor", 1'b0, 1'b1, 1'b1, 2'd3, D0, pk(8'h44, 2'd3, 1'b1, 1'b0, 1'b0), pk(8'h00, 2'd3, 1'b0, 1'b0, 1'b1));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
